uart_tx_arbiter: RTL

//  Shares the single UART transmit path (wr_uart/w_data/tx_full of uart) between NUM_REQ requesters.

---
 rtl/uart_tx_arbiter_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Latency: none; this package holds declarations only.
// Backpressure: none; this package holds declarations only.
package uart_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DBIT_DEF    = 8;

  // Width of an index able to address n requesters.
  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester side and UART side of the transmit arbiter, bundled as one port.
// Latency: none; this is wiring only.
// Backpressure: req_ready per requester, driven from the UART tx_full flag.
interface uart_tx_arbiter_if import uart_arb_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DBIT    = DBIT_DEF
);
  localparam int IW = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0][DBIT-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         wr_uart;
  logic [DBIT-1:0]              w_data;
  logic                         tx_full;
  logic                         grant_valid;
  logic [IW-1:0]                grant_id;
  logic                         timeout;

  // Requesters plus the UART FIFO, seen from outside the arbiter.
  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, wr_uart, w_data, grant_valid, grant_id, timeout
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, wr_uart, w_data, grant_valid, grant_id, timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none.
module rr_pick import uart_arb_pkg::*; #(
  parameter  int N  = NUM_REQ_DEF,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;

  // Walk indices starting at ptr; keep the first one that is requesting.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX path among NUM_REQ requesters, round-robin per whole message.
// Latency: 1 arbitration cycle before the first byte; one idle bubble between messages.
// Backpressure: tx_full stalls the owner (ready=0, no write); others wait. Watchdog: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int DBIT        = DBIT_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = id_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DBIT < 1 || TIMEOUT_CYC < 2) begin : g_param_err
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_id;
  logic          gnt_vld;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_ptr;
  logic          xfer;
  logic          wd_fire;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign xfer     = (state == ARB_HOLD) && bus.req_valid[gnt_id] && !bus.tx_full;
  assign next_ptr = (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  assign bus.grant_valid = gnt_vld;
  assign bus.grant_id    = gnt_id;

  // Route only the owner's handshake to the UART; everyone else sees ready=0.
  always_comb begin
    bus.req_ready = '0;
    bus.wr_uart   = 1'b0;
    bus.w_data    = '0;
    if (state == ARB_HOLD) begin
      bus.req_ready[gnt_id] = !bus.tx_full;
      bus.wr_uart           = xfer;
      if (xfer) bus.w_data = bus.req_data[gnt_id];
    end
  end

  // Arbitration FSM: grant in IDLE, hold until the last byte (or watchdog) releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      rr_ptr  <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            gnt_id  <= pick_idx;
            gnt_vld <= 1'b1;
            state   <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if ((xfer && bus.req_last[gnt_id]) || wd_fire) begin
            gnt_vld <= 1'b0;
            rr_ptr  <= next_ptr;
            state   <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] wd_cnt;
  logic          to_q;

  assign wd_fire     = (state == ARB_HOLD) && !bus.req_valid[gnt_id] && (wd_cnt == WD_MAX);
  assign bus.timeout = to_q;

  // Count owner-idle cycles in HOLD; any owner transfer restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      to_q <= wd_fire;
      if (state != ARB_HOLD || xfer || wd_fire) wd_cnt <= '0;
      else if (!bus.req_valid[gnt_id])          wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule
